day_offset_calc: RTL and testbench

//   Calendar day-offset calculator. Given the current day of the month, the

---
 rtl/day_calc_pkg.sv | 24 ++
 rtl/day_offset_wrap.sv | 42 ++++
 rtl/day_offset_calc.sv | 40 ++++
 tb/tb_day_offset_calc.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/day_calc_pkg.sv
// Shared constants and helpers for the day-of-month offset calculator.
// Month lengths, field widths and the month-length decode live here.
package day_calc_pkg;

   localparam int DAYS_SHORT = 30;
   localparam int DAYS_LONG  = 31;
   localparam int DAY_W      = 5;
   localparam int N_W        = 3;
   localparam int RAW_W      = DAY_W + 1;

   typedef logic [DAY_W-1:0] day_t;
   typedef logic [N_W-1:0]   offset_t;

   typedef struct packed {
      day_t dbn;
      day_t dan;
      logic err;
   } day_result_t;

   function automatic day_t dim_of(input logic day30_31);
      return day30_31 ? day_t'(DAYS_LONG) : day_t'(DAYS_SHORT);
   endfunction

endpackage : day_calc_pkg

// File: rtl/day_offset_wrap.sv
// Combinational core: days N before/after today with a single wrap across
// the month boundary, plus the illegal-day flag. The previous month is assumed to have length DIM.
module day_offset_wrap
   import day_calc_pkg::*;
(
   input  logic [DAY_W-1:0] today_i,
   input  logic [N_W-1:0]   n_i,
   input  logic [DAY_W-1:0] dim_i,
   output logic [DAY_W-1:0] dbn_o,
   output logic [DAY_W-1:0] dan_o,
   output logic             error_o
);

   logic signed [RAW_W-1:0] dbn_raw;
   logic        [RAW_W-1:0] dan_raw;

   // Both sums are one bit wider than a day so neither can overflow.
   assign dbn_raw = $signed({1'b0, today_i}) - $signed({{(RAW_W-N_W){1'b0}}, n_i});
   assign dan_raw = {1'b0, today_i} + {{(RAW_W-N_W){1'b0}}, n_i};

   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      dbn_o   = '0;
      dan_o   = '0;
      error_o = 1'b0;

      if ((today_i == '0) || (today_i > dim_i)) begin
         error_o = 1'b1;
      end else begin
         if (dbn_raw >= RAW_W'(signed'(1)))
            dbn_o = dbn_raw[DAY_W-1:0];
         else
            dbn_o = DAY_W'(dbn_raw + $signed({1'b0, dim_i}));

         if (dan_raw <= {1'b0, dim_i})
            dan_o = dan_raw[DAY_W-1:0];
         else
            dan_o = DAY_W'(dan_raw - {1'b0, dim_i});
      end
   end

endmodule : day_offset_wrap

// File: rtl/day_offset_calc.sv
// Registered day-offset calculator: one result per clock, one cycle of latency.
// Outputs clear asynchronously while rst is high.
module day_offset_calc
   import day_calc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [DAY_W-1:0] today,
   input  logic             day30_31,
   input  logic [N_W-1:0]   N,
   output logic [DAY_W-1:0] dbndays,
   output logic [DAY_W-1:0] dandays,
   output logic             error
);

   day_result_t res_d;
   day_result_t res_q;

   day_offset_wrap u_wrap (
      .today_i (today),
      .n_i     (N),
      .dim_i   (dim_of(day30_31)),
      .dbn_o   (res_d.dbn),
      .dan_o   (res_d.dan),
      .error_o (res_d.err)
   );

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      if (rst)
         res_q <= '0;
      else
         res_q <= res_d;
   end

   assign dbndays = res_q.dbn;
   assign dandays = res_q.dan;
   assign error   = res_q.err;

endmodule : day_offset_calc

// File: tb/tb_day_offset_calc.sv
// Self-checking bench for day_offset_calc: directed cases, async reset and a
// random sweep, all scored against an independent model via an expectation queue.
module tb_day_offset_calc;

   typedef struct {
      int dbn;
      int dan;
      int err;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [4:0] today;
   logic       day30_31;
   logic [2:0] N;
   logic [4:0] dbndays;
   logic [4:0] dandays;
   logic       error;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   day_offset_calc dut (
      .clk      (clk),
      .rst      (rst),
      .today    (today),
      .day30_31 (day30_31),
      .N        (N),
      .dbndays  (dbndays),
      .dandays  (dandays),
      .error    (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic exp_t model(input int t, input int d, input int n);
      exp_t e;
      int dim;
      dim = d ? 31 : 30;
      e.err = 0;
      e.dbn = 0;
      e.dan = 0;
      if (t == 0 || t > dim) begin
         e.err = 1;
      end else begin
         e.dbn = t - n;
         if (e.dbn < 1) e.dbn = e.dbn + dim;
         e.dan = t + n;
         if (e.dan > dim) e.dan = e.dan - dim;
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input int exp);
      n_cmp++;
      assert (obs === 8'(exp)) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input exp_t e);
      check({tag, ".dbndays"}, {3'b000, dbndays}, e.dbn);
      check({tag, ".dandays"}, {3'b000, dandays}, e.dan);
      check({tag, ".error"},   {7'b0, error},     e.err);
   endtask

   // Drive one set of inputs, queue its expectation, then score after the edge.
   task automatic step(input string tag, input int t, input int d, input int n);
      exp_t e;
      today    = 5'(t);
      day30_31 = d[0];
      N        = 3'(n);
      sb.push_back(model(t, d, n));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_outputs(tag, e);
   endtask

   initial begin
      exp_t zero;
      zero.dbn = 0;
      zero.dan = 0;
      zero.err = 0;

      rst      = 1'b1;
      today    = 5'd12;
      day30_31 = 1'b1;
      N        = 3'd4;
      #1;
      check_outputs("reset_async", zero);
      @(posedge clk);
      #1;
      check_outputs("reset_held_edge", zero);
      @(negedge clk);
      rst = 1'b0;

      step("err_31_in_30", 31, 0, 3);
      step("err_day0",      0, 0, 3);
      step("wrap_before",   3, 1, 3);
      step("wrap_after",   28, 0, 5);
      step("wrap_both31",  30, 1, 7);
      step("n0_identity",  15, 1, 0);
      step("max_31",       31, 1, 7);
      step("day1_n7_30",    1, 0, 7);
      step("no_wrap",      16, 0, 7);

      // Async reset mid-cycle with nonzero outputs, then release with held inputs.
      #2;
      rst = 1'b1;
      #1;
      check_outputs("reset_midcycle", zero);
      today    = 5'd10;
      N        = 3'd2;
      day30_31 = 1'b0;
      @(negedge clk);
      #1;
      check_outputs("reset_still_zero", zero);
      rst = 1'b0;
      sb.push_back(model(10, 0, 2));
      @(posedge clk);
      #1;
      check_outputs("after_release", sb.pop_front());

      for (int i = 0; i < 300; i++) begin
         step("sweep", int'($urandom_range(0, 31)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)));
      end

      check("sb_empty", 8'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_day_offset_calc
